// File: rtl/sb_pkg.sv
// Shared types and the hazard-code lookup for the register scoreboard.
// Optional build macro SCOREBOARD_WB_BYPASS_EN: when defined, the register file
// is write-first, so a writer sitting only in WB needs no stall (code 0).
// When undefined, a WB-only match reports a stall (code 1).
package sb_pkg;

    typedef logic [2:0] sb_code_t;

    localparam sb_code_t SB_READY   = 3'd0;
    localparam sb_code_t SB_STALL   = 3'd1;
    localparam sb_code_t SB_FWD_EX  = 3'd2;
    localparam sb_code_t SB_FWD_MEM = 3'd3;

    typedef struct packed {
        logic       valid;
        logic [2:0] dst;
        logic       is_load;
    } sb_entry_t;

    localparam int SB_NSTAGE = 3;

`ifdef SCOREBOARD_WB_BYPASS_EN
    // Write-first register file: the ID read already sees the WB value.
    localparam sb_code_t SB_WB_CODE = SB_READY;
`else
    // Read-before-write register file: ID must wait one more cycle.
    localparam sb_code_t SB_WB_CODE = SB_STALL;
`endif

    // Youngest matching valid writer wins: EX, then MEM, then WB.
    function automatic sb_code_t sb_lookup(input sb_entry_t ex_e,
                                           input sb_entry_t mem_e,
                                           input sb_entry_t wb_e,
                                           input logic [2:0] r);
        sb_code_t code;
        code = SB_READY;
        if (ex_e.valid && ex_e.dst == r)
            code = ex_e.is_load ? SB_STALL : SB_FWD_EX;
        else if (mem_e.valid && mem_e.dst == r)
            code = SB_FWD_MEM;
        else if (wb_e.valid && wb_e.dst == r)
            code = SB_WB_CODE;
        return code;
    endfunction

endpackage

// File: rtl/sb_stage.sv
// One scoreboard tracking entry that mirrors a pipeline register:
// flush beats enable, enable beats hold.
module sb_stage
    import sb_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    input  logic      en,
    input  sb_entry_t d,
    output sb_entry_t q
);

    sb_entry_t entry_reg;

    // Entry register: cleared on reset or flush, loaded on enable, else held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            entry_reg <= '0;
        else if (flush)
            entry_reg <= '0;
        else if (en)
            entry_reg <= d;
    end

    assign q = entry_reg;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writers in EX, MEM and WB and
// produces a per-register hazard/forwarding code for the ID-stage controller,
// plus a saturating stall-cycle counter.
// Optional build macro SCOREBOARD_WB_BYPASS_EN selects the WB-only code
// (see sb_pkg). Codes depend only on entry flops, never on inputs, so the
// controller may derive en/flush from them without a combinational loop.
module reg_scoreboard
    import sb_pkg::*;
#(
    parameter int NREG  = 8,
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        regwrite_cur,
    input  logic [2:0]                  regwrite_adr_id,
    input  logic                        from_main_mem_id,
    input  logic                        en_idex,
    input  logic                        flush_idex,
    input  logic                        en_exmem,
    input  logic                        flush_exmem,
    input  logic                        en_memwb,
    input  logic                        flush_memwb,
    input  logic                        stall_id,
    output sb_code_t [NREG-1:0]         register_invalid,
    output logic [CNT_W-1:0]            stall_cnt
);

    sb_entry_t [SB_NSTAGE-1:0] stage_d;
    sb_entry_t [SB_NSTAGE-1:0] stage_q;
    logic      [SB_NSTAGE-1:0] stage_flush;
    logic      [SB_NSTAGE-1:0] stage_en;

    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_next;

    // Stage 0 = EX, 1 = MEM, 2 = WB.
    assign stage_flush = {flush_memwb, flush_exmem, flush_idex};
    assign stage_en    = {en_memwb,    en_exmem,    en_idex};

    genvar gi;
    generate
        for (gi = 0; gi < SB_NSTAGE; gi++) begin : g_stage
            if (gi == 0) begin : g_src_id
                assign stage_d[gi] = '{valid:   regwrite_cur,
                                       dst:     regwrite_adr_id,
                                       is_load: from_main_mem_id};
            end else begin : g_src_prev
                assign stage_d[gi] = stage_q[gi-1];
            end

            sb_stage u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .flush (stage_flush[gi]),
                .en    (stage_en[gi]),
                .d     (stage_d[gi]),
                .q     (stage_q[gi])
            );
        end

        for (gi = 0; gi < NREG; gi++) begin : g_code
            assign register_invalid[gi] =
                sb_lookup(stage_q[0], stage_q[1], stage_q[2], 3'(gi));
        end
    endgenerate

    // Next stall count: increment on a stalled cycle, stick at all-ones.
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (stall_id && (stall_cnt_reg != {CNT_W{1'b1}}))
            stall_cnt_next = stall_cnt_reg + 1'b1;
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_reg <= '0;
        else
            stall_cnt_reg <= stall_cnt_next;
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed testbench for reg_scoreboard (small stall counter for saturation).
`timescale 1ns/1ps
module tb_reg_scoreboard;
    import sb_pkg::*;

    localparam int NREG  = 8;
    localparam int CNT_W = 4;

`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam int WB_EXP = 0;
`else
    localparam int WB_EXP = 1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic regwrite_cur;
    logic [2:0] regwrite_adr_id;
    logic from_main_mem_id;
    logic en_idex, flush_idex, en_exmem, flush_exmem, en_memwb, flush_memwb;
    logic stall_id;
    sb_code_t [NREG-1:0] register_invalid;
    logic [CNT_W-1:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    reg_scoreboard #(.NREG(NREG), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .regwrite_cur     (regwrite_cur),
        .regwrite_adr_id  (regwrite_adr_id),
        .from_main_mem_id (from_main_mem_id),
        .en_idex          (en_idex),
        .flush_idex       (flush_idex),
        .en_exmem         (en_exmem),
        .flush_exmem      (flush_exmem),
        .en_memwb         (en_memwb),
        .flush_memwb      (flush_memwb),
        .stall_id         (stall_id),
        .register_invalid (register_invalid),
        .stall_cnt        (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [2:0] adr, input logic ld);
        regwrite_cur     = wr;
        regwrite_adr_id  = adr;
        from_main_mem_id = ld;
    endtask

    task automatic check_all_zero(input string tag);
        for (int r = 0; r < NREG; r++)
            check($sformatf("%s_r%0d", tag, r), int'(register_invalid[r]), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        issue(1'b0, 3'd0, 1'b0);
        en_idex = 1'b1; en_exmem = 1'b1; en_memwb = 1'b1;
        flush_idex = 1'b0; flush_exmem = 1'b0; flush_memwb = 1'b0;
        stall_id = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset release, nothing issued.
        step();
        check_all_zero("reset");
        check("reset_cnt", int'(stall_cnt), 0);

        // ADD r3 walks through the pipe.
        issue(1'b1, 3'd3, 1'b0); step();
        check("add_ex_r3", int'(register_invalid[3]), 2);
        issue(1'b0, 3'd0, 1'b0); step();
        check("add_mem_r3", int'(register_invalid[3]), 3);
        step();
        check("add_wb_r3", int'(register_invalid[3]), WB_EXP);
        step();
        check("add_done_r3", int'(register_invalid[3]), 0);

        // LD r5 followed by a controller-inserted bubble.
        issue(1'b1, 3'd5, 1'b1); step();
        check("ld_ex_r5", int'(register_invalid[5]), 1);
        issue(1'b0, 3'd0, 1'b0);
        flush_idex = 1'b1; stall_id = 1'b1; step();
        check("ld_mem_r5", int'(register_invalid[5]), 3);
        check("ld_stall_cnt", int'(stall_cnt), 1);
        flush_idex = 1'b0; stall_id = 1'b0; step();
        check("ld_wb_r5", int'(register_invalid[5]), WB_EXP);
        step();
        check("ld_done_r5", int'(register_invalid[5]), 0);

        // Back-to-back writers to r2: younger EX beats older MEM.
        issue(1'b1, 3'd2, 1'b1); step();
        check("b2b_ld_r2", int'(register_invalid[2]), 1);
        issue(1'b1, 3'd2, 1'b0); step();
        check("b2b_young_r2", int'(register_invalid[2]), 2);
        issue(1'b0, 3'd0, 1'b0); step();
        check("b2b_mem_r2", int'(register_invalid[2]), 3);
        step();
        check("b2b_wb_r2", int'(register_invalid[2]), WB_EXP);
        step();
        check("b2b_done_r2", int'(register_invalid[2]), 0);

        // Jump with r1 in EX and r4 in MEM; an issue to r6 in the same cycle
        // must be dropped because flush wins.
        issue(1'b1, 3'd4, 1'b0); step();
        issue(1'b1, 3'd1, 1'b0); step();
        check("jmp_pre_r1", int'(register_invalid[1]), 2);
        check("jmp_pre_r4", int'(register_invalid[4]), 3);
        issue(1'b1, 3'd6, 1'b1);
        flush_idex = 1'b1; flush_exmem = 1'b1; step();
        check("jmp_r1", int'(register_invalid[1]), 0);
        check("jmp_r4_wb", int'(register_invalid[4]), WB_EXP);
        check("jmp_r6_flushed", int'(register_invalid[6]), 0);
        issue(1'b0, 3'd0, 1'b0);
        flush_idex = 1'b0; flush_exmem = 1'b0; step();
        check_all_zero("jmp_after");

        // Stall counter saturation (count is 1 here).
        stall_id = 1'b1;
        repeat (13) step();
        check("cnt_14", int'(stall_cnt), 14);
        step();
        check("cnt_15", int'(stall_cnt), 15);
        repeat (3) step();
        check("cnt_sat", int'(stall_cnt), 15);
        stall_id = 1'b0;

        // Fill all three stages, then assert reset between edges.
        issue(1'b1, 3'd0, 1'b1); step();
        issue(1'b1, 3'd1, 1'b0); step();
        issue(1'b1, 3'd2, 1'b0); step();
        issue(1'b0, 3'd0, 1'b0);
        check("fill_r2", int'(register_invalid[2]), 2);
        check("fill_r1", int'(register_invalid[1]), 3);
        check("fill_r0", int'(register_invalid[0]), WB_EXP);
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("arst");
        check("arst_cnt", int'(stall_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
